riscv_test_monitor: RTL

Synthesizable pass/fail monitor for riscv-tests programs run on `risc_v_cpu`. It snoops the register-file write port and tracks the done flag (default x26), the pass flag (default x27) and the test number (default x3). After a done write it waits a settle window, then latches a sticky PASS/FAIL verdict; a watchdog raises TIMEOUT if done never arrives. It sits beside `risc_v_top` and replaces hierarchical register peeking, so the verdict works in simulation, emulation and FPGA.

---
 rtl/riscv_test_pkg.sv | 22 ++
 rtl/riscv_test_monitor_if.sv | 26 ++
 rtl/sat_counter.sv | 31 +++
 rtl/riscv_test_monitor.sv | 124 ++++++++++++
 4 files changed

// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the riscv-tests pass/fail monitor.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StSettle  = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } state_e;

  localparam int unsigned DefaultDoneReg = 26;
  localparam int unsigned DefaultPassReg = 27;
  localparam int unsigned DefaultTnumReg = 3;
  localparam int unsigned TEST_PASS_VAL  = 1;

  // Shadows may only change while the test is still running or settling.
  function automatic logic is_active(input state_e s);
    return (s == StRun) || (s == StSettle);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Register-file snoop inputs and verdict outputs of the test monitor.
interface riscv_test_monitor_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             clear_i;
  logic             we_i;
  logic [4:0]       waddr_i;
  logic [XLEN-1:0]  wdata_i;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic [XLEN-1:0]  test_num_o;
  logic [CNT_W-1:0] cycles_o;

  modport master (
    output clear_i, we_i, waddr_i, wdata_i,
    input  done_o, pass_o, fail_o, timeout_o, test_num_o, cycles_o
  );

  modport slave (
    input  clear_i, we_i, waddr_i, wdata_i,
    output done_o, pass_o, fail_o, timeout_o, test_num_o, cycles_o
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);
  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/riscv_test_monitor.sv
// Snoops register-file writes of a riscv-tests program and latches a sticky
// PASS/FAIL/TIMEOUT verdict after a settle window following the done write.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DONE_REG       = DefaultDoneReg,
  parameter int unsigned PASS_REG       = DefaultPassReg,
  parameter int unsigned TNUM_REG       = DefaultTnumReg,
  parameter int unsigned SETTLE_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 32
) (
  input logic                 clk,
  input logic                 rst,
  riscv_test_monitor_if.slave mon
);
  localparam int unsigned SetW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] cycles_q;
  logic [SetW-1:0]  set_cnt;
  logic [XLEN-1:0]  pass_sh, tnum_sh;
  logic             wr_ok, done_wr, pass_wr, tnum_wr;
  logic             settle_last, tmo_hit, pass_ok;

  // x0 is hard-wired zero on the CPU, so writes to it never reach a shadow.
  assign wr_ok   = mon.we_i && (mon.waddr_i != 5'd0);
  assign done_wr = wr_ok && (mon.waddr_i == 5'(DONE_REG)) &&
                   (mon.wdata_i == XLEN'(TEST_PASS_VAL));
  assign pass_wr = wr_ok && (mon.waddr_i == 5'(PASS_REG));
  assign tnum_wr = wr_ok && (mon.waddr_i == 5'(TNUM_REG));

  assign settle_last = (set_cnt == SettleLast);
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (cyc == TimeoutLast);
  assign pass_ok     = (pass_sh == XLEN'(TEST_PASS_VAL));

  sat_counter #(
    .Width (CNT_W)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mon.clear_i),
    .en_i  (state_q == StRun),
    .cnt_o (cyc)
  );

  // Held at zero outside SETTLE so every settle window starts from 0.
  sat_counter #(
    .Width (SetW)
  ) u_set_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mon.clear_i || (state_q != StSettle)),
    .en_i  (state_q == StSettle),
    .cnt_o (set_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (done_wr) begin
          state_d = StSettle;
        end else if (tmo_hit) begin
          state_d = StTimeout;
        end
      end
      StSettle: begin
        if (settle_last) begin
          state_d = pass_ok ? StPass : StFail;
        end
      end
      default: state_d = state_q;
    endcase
    if (mon.clear_i) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate on the next state so a write landing on the verdict edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_sh <= '0;
      tnum_sh <= '0;
    end else if (mon.clear_i) begin
      pass_sh <= '0;
      tnum_sh <= '0;
    end else if (is_active(state_d)) begin
      if (pass_wr) pass_sh <= mon.wdata_i;
      if (tnum_wr) tnum_sh <= mon.wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (mon.clear_i) begin
      cycles_q <= '0;
    end else if ((state_q == StRun) && done_wr) begin
      cycles_q <= cyc;
    end
  end

  assign mon.pass_o     = (state_q == StPass);
  assign mon.fail_o     = (state_q == StFail);
  assign mon.timeout_o  = (state_q == StTimeout);
  assign mon.done_o     = (state_q == StPass) || (state_q == StFail) ||
                          (state_q == StTimeout);
  assign mon.test_num_o = tnum_sh;
  assign mon.cycles_o   = cycles_q;
endmodule
